// File: rtl/bram_wr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_wr_arbiter : round-robin burst-write arbiter for BRAM port A
// Revision 1.0
// ----------------------------------------------------------------------------
module bram_wr_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 7,
  parameter int BURST_LEN = 50,
  parameter int BASE0     = 0,
  parameter int BASE1     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        wr_valid,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [1:0]        abort,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [6:0]        CNT_LAST = 7'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE0_A  = ADDR_W'(BASE0);
  localparam logic [ADDR_W-1:0] BASE1_A  = ADDR_W'(BASE1);

  state_t            state;
  logic              last;
  logic [6:0]        cnt;

  // Everything below is steered by which requester currently owns the port.
  logic              sel;
  logic              beat;
  logic              req_cur;
  logic [DATA_W-1:0] data_cur;
  logic [ADDR_W-1:0] base_cur;

  assign sel      = (state == GRANT1);
  assign beat     = sel ? wr_valid[1] : wr_valid[0];
  assign req_cur  = sel ? req[1] : req[0];
  assign data_cur = sel ? wr_data1 : wr_data0;
  assign base_cur = sel ? BASE1_A : BASE0_A;

  assign gnt = {state == GRANT1, state == GRANT0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      done  <= '0;
      abort <= '0;
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      done  <= '0;
      abort <= '0;
      ena   <= 1'b0;
      wea   <= 1'b0;
      case (state)
        IDLE: begin
          if (req[0] && (!req[1] || last)) begin
            state <= GRANT0;
            last  <= 1'b0;
            cnt   <= '0;
          end else if (req[1]) begin
            state <= GRANT1;
            last  <= 1'b1;
            cnt   <= '0;
          end
        end
        GRANT0, GRANT1: begin
          // The final beat completes even if the request drops with it.
          if (beat && (cnt == CNT_LAST)) begin
            ena       <= 1'b1;
            wea       <= 1'b1;
            addra     <= base_cur + ADDR_W'(cnt);
            dina      <= data_cur;
            done[sel] <= 1'b1;
            state     <= IDLE;
          end else if (!req_cur) begin
            abort[sel] <= 1'b1;
            state      <= IDLE;
          end else if (beat) begin
            ena   <= 1'b1;
            wea   <= 1'b1;
            addra <= base_cur + ADDR_W'(cnt);
            dina  <= data_cur;
            cnt   <= cnt + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
